// File: rtl/cordic_vec_post_if.sv
// Handshake and result bundle between cordic_vec and its post-processing stage.
interface cordic_vec_post_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_phase;
  logic [WIDTH-1:0] in_magnitude;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] magnitude;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] phase_delta;
  logic             first;

  modport master (
    output in_valid, in_phase, in_magnitude,
    input  ready, done, magnitude, phase, phase_delta, first
  );

  modport slave (
    input  in_valid, in_phase, in_magnitude,
    output ready, done, magnitude, phase, phase_delta, first
  );
endinterface

// File: rtl/cordic_vec_post.sv
// CORDIC vectoring post-stage: removes gain via bit-serial multiply by K and
// produces the wrapped phase step to the previous sample.
module cordic_vec_post #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] GAIN_Q = WIDTH'(32'h9B74EDA8)
) (
  input logic              clk,
  input logic              reset,
  cordic_vec_post_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ACC_W-1:0]   acc, acc_d, acc_sum;
  logic [ACC_W-1:0]   mcand, mcand_d;
  logic [WIDTH-1:0]   mplier, mplier_d;
  logic [WIDTH-1:0]   cap_phase, cap_phase_d;
  logic [WIDTH-1:0]   prev_phase, prev_phase_d;
  logic               have_prev, have_prev_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               first_q, first_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [WIDTH-1:0]   phase_q, phase_d;
  logic [WIDTH-1:0]   delta_q, delta_d;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    acc_d        = acc;
    mcand_d      = mcand;
    mplier_d     = mplier;
    cap_phase_d  = cap_phase;
    prev_phase_d = prev_phase;
    have_prev_d  = have_prev;
    done_d       = 1'b0;
    first_d      = 1'b0;
    mag_d        = mag_q;
    phase_d      = phase_q;
    delta_d      = delta_q;
    acc_sum      = acc + (mplier[0] ? mcand : '0);

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          cap_phase_d = bus.in_phase;
          mplier_d    = bus.in_magnitude;
          mcand_d     = {WIDTH'(0), GAIN_Q};
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = MUL;
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
        cnt_d    = cnt + CNT_W'(1);
        // Last multiplier bit: the final partial sum feeds the outputs directly
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_d      = DONE;
          mag_d        = acc_sum[ACC_W-1:WIDTH];
          phase_d      = cap_phase;
          delta_d      = have_prev ? (cap_phase - prev_phase) : '0;
          first_d      = ~have_prev;
          done_d       = 1'b1;
          prev_phase_d = cap_phase;
          have_prev_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cap_phase  <= '0;
      prev_phase <= '0;
      have_prev  <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      first_q    <= 1'b0;
      mag_q      <= '0;
      phase_q    <= '0;
      delta_q    <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      acc        <= acc_d;
      mcand      <= mcand_d;
      mplier     <= mplier_d;
      cap_phase  <= cap_phase_d;
      prev_phase <= prev_phase_d;
      have_prev  <= have_prev_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      first_q    <= first_d;
      mag_q      <= mag_d;
      phase_q    <= phase_d;
      delta_q    <= delta_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.first       = first_q;
  assign bus.magnitude   = mag_q;
  assign bus.phase       = phase_q;
  assign bus.phase_delta = delta_q;

endmodule

// File: tb/tb_cordic_vec_post.sv
// Randomized self-checking bench for cordic_vec_post against an arithmetic model.
module tb_cordic_vec_post;

  localparam logic [63:0] GAIN = 64'd2608131496;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] m_prev = '0;
  logic        m_have = 1'b0;

  cordic_vec_post_if #(.WIDTH(32)) bus ();

  cordic_vec_post #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mag(input logic [31:0] m);
    logic [63:0] p;
    p = 64'(m) * GAIN;
    return p[63:32];
  endfunction

  task automatic model_next(input logic [31:0] ph, output logic [31:0] d, output logic f);
    d      = m_have ? ph - m_prev : 32'd0;
    f      = ~m_have;
    m_prev = ph;
    m_have = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, issues a one-cycle in_valid, and counts edges until done.
  task automatic send(input logic [31:0] ph, input logic [31:0] mg,
                      output int edges, output bit rdy_seen);
    int guard = 0;
    while (!bus.ready && guard < 100) begin tick(); guard++; end
    bus.in_phase     = ph;
    bus.in_magnitude = mg;
    bus.in_valid     = 1'b1;
    tick();
    edges        = 1;
    bus.in_valid = 1'b0;
    rdy_seen     = bus.ready;
    while (!bus.done && edges < 100) begin
      tick();
      edges++;
      if (bus.ready) rdy_seen = 1'b1;
    end
    if (!bus.done) edges = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    m_have = 1'b0;
    m_prev = '0;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", bus.ready); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.magnitude !== 32'd0) $display("FAIL reset_mag got %0h want 0", bus.magnitude); else n_pass++;
    n_checks++; if (bus.phase !== 32'd0 || bus.phase_delta !== 32'd0 || bus.first !== 1'b0)
      $display("FAIL reset_outs got ph=%0h d=%0h f=%0b want 0", bus.phase, bus.phase_delta, bus.first);
    else n_pass++;
  endtask

  task automatic test_basic();
    int edges; bit rdy; logic [31:0] d; logic f;
    send(32'h40000000, 32'h80000000, edges, rdy);
    model_next(32'h40000000, d, f);
    n_checks++; if (edges !== 33) $display("FAIL basic_latency got %0d want 33", edges); else n_pass++;
    n_checks++; if (rdy !== 1'b0) $display("FAIL basic_ready_low got %0b want 0", rdy); else n_pass++;
    n_checks++; if (bus.magnitude !== 32'd1304065748) $display("FAIL basic_mag got %0d want 1304065748", bus.magnitude); else n_pass++;
    n_checks++; if (bus.phase !== 32'h40000000) $display("FAIL basic_phase got %0h want 40000000", bus.phase); else n_pass++;
    n_checks++; if (bus.phase_delta !== 32'd0 || bus.first !== 1'b1)
      $display("FAIL basic_first got d=%0h f=%0b want d=0 f=1", bus.phase_delta, bus.first);
    else n_pass++;
    tick();
    n_checks++; if (bus.done !== 1'b0 || bus.first !== 1'b0 || bus.ready !== 1'b1)
      $display("FAIL basic_pulse got done=%0b first=%0b ready=%0b want 0 0 1", bus.done, bus.first, bus.ready);
    else n_pass++;
    n_checks++; if (bus.magnitude !== 32'd1304065748) $display("FAIL basic_hold got %0d want 1304065748", bus.magnitude); else n_pass++;
  endtask

  task automatic test_gain();
    logic [31:0] mags [3] = '{32'd0, 32'hFFFFFFFF, 32'd1};
    logic [31:0] want [3] = '{32'd0, 32'd2608131495, 32'd0};
    int edges; bit rdy; logic [31:0] d; logic f;
    for (int i = 0; i < 3; i++) begin
      send(32'h01000000 * i, mags[i], edges, rdy);
      model_next(32'h01000000 * i, d, f);
      n_checks++; if (edges !== 33 || bus.magnitude !== want[i])
        $display("FAIL gain_%0d got lat=%0d mag=%0d want lat=33 mag=%0d", i, edges, bus.magnitude, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_phase_wrap();
    logic [31:0] phs  [3] = '{32'hF0000000, 32'h10000000, 32'hF0000000};
    int edges; bit rdy; logic [31:0] d; logic f;
    for (int i = 0; i < 3; i++) begin
      send(phs[i], 32'h12345678, edges, rdy);
      model_next(phs[i], d, f);
      n_checks++; if (bus.phase_delta !== d || bus.first !== f || bus.phase !== phs[i])
        $display("FAIL wrap_%0d got d=%0h f=%0b ph=%0h want d=%0h f=%0b ph=%0h",
                 i, bus.phase_delta, bus.first, bus.phase, d, f, phs[i]);
      else n_pass++;
    end
    n_checks++; if (bus.phase_delta !== 32'hE0000000) $display("FAIL wrap_neg got %0h want e0000000", bus.phase_delta); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t = 0; int ndone = 0; int last = 0;
    logic [31:0] ph = $urandom; logic [31:0] mg = $urandom; logic [31:0] d; logic f;
    while (!bus.ready) tick();
    bus.in_phase = ph; bus.in_magnitude = mg; bus.in_valid = 1'b1;
    while (ndone < 3 && t < 200) begin
      tick(); t++;
      if (bus.done) begin
        model_next(ph, d, f);
        if (ndone > 0) begin
          n_checks++; if (t - last !== 34) $display("FAIL b2b_period got %0d want 34", t - last); else n_pass++;
        end
        n_checks++; if (bus.magnitude !== ref_mag(mg) || bus.phase_delta !== d || bus.first !== f)
          $display("FAIL b2b_out got m=%0d d=%0h f=%0b want m=%0d d=%0h f=%0b",
                   bus.magnitude, bus.phase_delta, bus.first, ref_mag(mg), d, f);
        else n_pass++;
        last = t; ndone++;
        if (ndone == 3) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (ndone !== 3) $display("FAIL b2b_count got %0d want 3", ndone); else n_pass++;
  endtask

  task automatic test_midmul_ignore();
    int t = 0; int extra = 0; int seen_at = -1;
    logic [31:0] ph = $urandom; logic [31:0] mg = $urandom; logic [31:0] d; logic f;
    while (!bus.ready) tick();
    bus.in_phase = ph; bus.in_magnitude = mg; bus.in_valid = 1'b1;
    tick(); t = 1; bus.in_valid = 1'b0;
    while (seen_at < 0 && t < 100) begin
      if (t == 10) begin bus.in_valid = 1'b1; bus.in_phase = ~ph; bus.in_magnitude = ~mg; end
      if (t == 11) bus.in_valid = 1'b0;
      tick(); t++;
      if (bus.done) seen_at = t;
    end
    model_next(ph, d, f);
    n_checks++; if (seen_at !== 33 || bus.phase !== ph || bus.magnitude !== ref_mag(mg) || bus.phase_delta !== d)
      $display("FAIL midmul_out got t=%0d ph=%0h m=%0d d=%0h want t=33 ph=%0h m=%0d d=%0h",
               seen_at, bus.phase, bus.magnitude, bus.phase_delta, ph, ref_mag(mg), d);
    else n_pass++;
    repeat (80) begin tick(); if (bus.done) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL midmul_extra got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_reset_midmul();
    int edges; bit rdy; logic [31:0] d; logic f; logic [31:0] ph = $urandom | 32'h1;
    while (!bus.ready) tick();
    bus.in_phase = 32'h55555555; bus.in_magnitude = 32'hFFFFFFFF; bus.in_valid = 1'b1;
    tick(); bus.in_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_have = 1'b0; m_prev = '0;
    n_checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) $display("FAIL rstmid_ctl got r=%0b d=%0b want 1 0", bus.ready, bus.done); else n_pass++;
    n_checks++; if (bus.magnitude !== 32'd0 || bus.phase !== 32'd0 || bus.phase_delta !== 32'd0 || bus.first !== 1'b0)
      $display("FAIL rstmid_outs got m=%0h ph=%0h d=%0h f=%0b want 0", bus.magnitude, bus.phase, bus.phase_delta, bus.first);
    else n_pass++;
    send(ph, 32'h0000FFFF, edges, rdy);
    model_next(ph, d, f);
    n_checks++; if (edges !== 33 || bus.first !== 1'b1 || bus.phase_delta !== 32'd0 || bus.magnitude !== ref_mag(32'h0000FFFF))
      $display("FAIL rstmid_first got lat=%0d f=%0b d=%0h m=%0d want 33 1 0 %0d",
               edges, bus.first, bus.phase_delta, bus.magnitude, ref_mag(32'h0000FFFF));
    else n_pass++;
  endtask

  task automatic test_random();
    int edges; bit rdy; logic [31:0] d; logic f; logic [31:0] ph; logic [31:0] mg;
    for (int i = 0; i < 20; i++) begin
      ph = $urandom; mg = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      send(ph, mg, edges, rdy);
      model_next(ph, d, f);
      n_checks++; if (edges !== 33 || rdy !== 1'b0 || bus.magnitude !== ref_mag(mg) || bus.phase !== ph ||
                      bus.phase_delta !== d || bus.first !== f)
        $display("FAIL rand_%0d got lat=%0d m=%0d ph=%0h d=%0h f=%0b want 33 m=%0d ph=%0h d=%0h f=%0b",
                 i, edges, bus.magnitude, bus.phase, bus.phase_delta, bus.first, ref_mag(mg), ph, d, f);
      else n_pass++;
    end
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_phase     = '0;
    bus.in_magnitude = '0;
    #2;
    test_reset();
    test_basic();
    test_gain();
    test_phase_wrap();
    test_back_to_back();
    test_midmul_ignore();
    test_reset_midmul();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
